systolic_ctrl: RTL

- Sequencer for an N x N weight-stationary systolic array built from the team's pe tiles.
- Per job, it loads weights (per-column accept_w), then streams input vectors with per-row skew and per-row switch pulses, then drains and reports completion.
- Sits between the host/job interface and the array top level; it drives only control, and data paths come from the weight and input buffers.

---
 rtl/tpu_pkg.sv | 21 ++
 rtl/systolic_ctrl_if.sv | 32 +++
 rtl/systolic_ctrl_skew_gen.sv | 50 +++++
 rtl/systolic_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array control slice.
// Contents: controller state enum, default array dimension and the
// drain-length helper used to size the post-stream flush window.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int N_DEFAULT = 2;

  // Cycles needed after the last input enters for partial sums to leave the array.
  function automatic int drain_len(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Job/control bundle between the host side and the systolic array sequencer.
// master: job source (start, num_vectors, reuse_w, flush) observing status/control.
// slave : the sequencer, driving busy/done and every array control strobe.
interface systolic_ctrl_if
  import tpu_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int LEN_WIDTH = 8
);
  logic                 start;
  logic [LEN_WIDTH-1:0] num_vectors;
  logic                 reuse_w;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic                 array_en;
  logic                 w_rd_en;
  logic [$clog2(N)-1:0] w_row_idx;
  logic [N-1:0]         accept_w_col;
  logic [N-1:0]         valid_row;
  logic [N-1:0]         switch_row;

  modport master (
    output start, num_vectors, reuse_w, flush,
    input  busy, done, array_en, w_rd_en, w_row_idx, accept_w_col, valid_row, switch_row
  );

  modport slave (
    input  start, num_vectors, reuse_w, flush,
    output busy, done, array_en, w_rd_en, w_row_idx, accept_w_col, valid_row, switch_row
  );
endinterface

// File: rtl/systolic_ctrl_skew_gen.sv
// Per-row skew generator for the input stream.
// Ports: clk, rst (async active-low), active_i (stream phase), t_i (stream
// counter), nv_i (vectors in job), sw_en_i (emit switch pulses),
// valid_row_o / switch_row_o (registered per-row strobes).
module skew_gen
  import tpu_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int LEN_WIDTH = 8,
  parameter int CNT_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active_i,
  input  logic [CNT_WIDTH-1:0] t_i,
  input  logic [LEN_WIDTH-1:0] nv_i,
  input  logic                 sw_en_i,
  output logic [N-1:0]         valid_row_o,
  output logic [N-1:0]         switch_row_o
);

  logic [N-1:0] valid_row_d, valid_row_q;
  logic [N-1:0] switch_row_d, switch_row_q;

  // Row r is skewed by r cycles: it carries vectors while r <= t < r + nv.
  always_comb begin
    valid_row_d  = '0;
    switch_row_d = '0;
    for (int r = 0; r < N; r++) begin
      if (active_i && (t_i >= CNT_WIDTH'(r)) && ((t_i - CNT_WIDTH'(r)) < CNT_WIDTH'(nv_i)))
        valid_row_d[r] = 1'b1;
      if (active_i && sw_en_i && (t_i == CNT_WIDTH'(r)))
        switch_row_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_row_q  <= '0;
      switch_row_q <= '0;
    end else begin
      valid_row_q  <= valid_row_d;
      switch_row_q <= switch_row_d;
    end
  end

  assign valid_row_o  = valid_row_q;
  assign switch_row_o = switch_row_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N weight-stationary systolic array.
// Ports: clk, rst (async active-low), bus (systolic_ctrl_if.slave):
//   start/num_vectors/reuse_w/flush in; busy/done/array_en/w_rd_en/
//   w_row_idx/accept_w_col/valid_row/switch_row out, all registered.
// Flow per job: LOAD_W (N cycles, skipped on reuse) -> STREAM (nv+N-1)
// -> DRAIN (2N) -> DONE (1).
module systolic_ctrl
  import tpu_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int LEN_WIDTH = 8,
  parameter int CNT_WIDTH = 9
) (
  input  logic            clk,
  input  logic            rst,
  systolic_ctrl_if.slave  bus
);

  localparam int IW = $clog2(N);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] nv_q, nv_d;
  logic                 reuse_q, reuse_d;
  logic                 array_en_q, array_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 w_rd_en_q, w_rd_en_d;
  logic [IW-1:0]        w_row_idx_q, w_row_idx_d;
  logic [N-1:0]         accept_w_col_q, accept_w_col_d;
  logic [CNT_WIDTH-1:0] stream_last, drain_last;

  assign stream_last = CNT_WIDTH'(nv_q) + CNT_WIDTH'(N - 2);
  assign drain_last  = CNT_WIDTH'(drain_len(N) - 1);

  // Outputs are derived from the next state so they appear in the same
  // cycle the state is entered, while still coming straight from flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nv_d       = nv_q;
    reuse_d    = reuse_q;
    array_en_d = array_en_q;
    unique case (state_q)
      IDLE: begin
        if (bus.flush) array_en_d = 1'b0;
        if (bus.start && (bus.num_vectors != '0)) begin
          nv_d       = bus.num_vectors;
          reuse_d    = bus.reuse_w;
          array_en_d = 1'b1;
          cnt_d      = '0;
          state_d    = bus.reuse_w ? STREAM : LOAD_W;
        end
      end
      LOAD_W: begin
        if (cnt_q == CNT_WIDTH'(N - 1)) begin
          state_d = STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STREAM: begin
        if (cnt_q == stream_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == drain_last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
    w_rd_en_d      = (state_d == LOAD_W);
    accept_w_col_d = {N{state_d == LOAD_W}};
    // Bottom weight row is fed first so it ends up deepest in the columns.
    w_row_idx_d    = (state_d == LOAD_W) ? IW'(CNT_WIDTH'(N - 1) - cnt_d) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      nv_q           <= '0;
      reuse_q        <= 1'b0;
      array_en_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      w_rd_en_q      <= 1'b0;
      w_row_idx_q    <= '0;
      accept_w_col_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      nv_q           <= nv_d;
      reuse_q        <= reuse_d;
      array_en_q     <= array_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      w_rd_en_q      <= w_rd_en_d;
      w_row_idx_q    <= w_row_idx_d;
      accept_w_col_q <= accept_w_col_d;
    end
  end

  skew_gen #(
    .N         (N),
    .LEN_WIDTH (LEN_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_skew (
    .clk          (clk),
    .rst          (rst),
    .active_i     (state_d == STREAM),
    .t_i          (cnt_d),
    .nv_i         (nv_d),
    .sw_en_i      (!reuse_d),
    .valid_row_o  (bus.valid_row),
    .switch_row_o (bus.switch_row)
  );

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.array_en     = array_en_q;
  assign bus.w_rd_en      = w_rd_en_q;
  assign bus.w_row_idx    = w_row_idx_q;
  assign bus.accept_w_col = accept_w_col_q;

endmodule
